// File: rtl/deck_draw_scheduler.sv
// deck_draw_scheduler
//   Sequences the shared UNO card deck. On a new game it shuffles the deck.
//   When DECK_SCHED_DEAL_EN is defined it also deals HAND cards to each of the
//   NP players. After that it serves per-player draw-1/2/4 requests
//   round-robin, and it splits every request into single-card deck
//   transactions. This block is the only driver of the deck's start and draw
//   inputs.
//
//   Optional feature macro: DECK_SCHED_DEAL_EN (opening deal after shuffle).
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_new_game          1-cycle pulse: shuffle (then deal) for a new game
//   i_req[NP]           per-player draw request, held until o_req_done[p]
//   i_cnt[3*NP]         per-player one-hot draw code (001=1, 010=2, 100=4)
//   o_grant[NP]         one-hot player currently being served
//   o_req_done[NP]      1-cycle pulse when a player's request completes
//   o_card_valid        1-cycle pulse qualifying o_card / o_card_player
//   o_card[6]           card {color[1:0], value[3:0]}, forwarded unmodified
//   o_card_player[PW]   destination player of o_card
//   o_busy              high whenever the scheduler is not idle
//   o_deck_start        1-cycle shuffle pulse to the deck
//   i_deck_done         deck idle / ready
//   o_deck_draw[3]      single-card draw request (001) to the deck
//   i_deck_drawn        deck presents a card on i_deck_card
//   i_deck_card[6]      card from the deck
module deck_draw_scheduler #(
  parameter int NP   = 4,
  parameter int PW   = (NP > 1) ? $clog2(NP) : 1,
  parameter int HAND = 7
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_new_game,
  input  logic [NP-1:0]   i_req,
  input  logic [3*NP-1:0] i_cnt,
  output logic [NP-1:0]   o_grant,
  output logic [NP-1:0]   o_req_done,
  output logic            o_card_valid,
  output logic [5:0]      o_card,
  output logic [PW-1:0]   o_card_player,
  output logic            o_busy,
  output logic            o_deck_start,
  input  logic            i_deck_done,
  output logic [2:0]      o_deck_draw,
  input  logic            i_deck_drawn,
  input  logic [5:0]      i_deck_card
);

  // The remaining counter must also hold the whole opening deal.
  localparam int RW = ($clog2(NP*HAND+1) > 3) ? $clog2(NP*HAND+1) : 3;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_SHUF, S_DEAL, S_ARB, S_REQ, S_DLV, S_GAP
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [PW-1:0]   r_rr;
  logic [PW-1:0]   r_player;
  logic [RW-1:0]   r_remain;
  logic [5:0]      r_card;
  logic [NP-1:0]   r_grant;
  logic            r_started;
  logic            r_shuf_min;   // set once S_SHUF has lasted one cycle
  logic            r_dealing;    // current S_REQ/S_DLV/S_GAP loop is the deal

  logic            w_found;
  logic [PW-1:0]   w_sel;
  logic [2:0]      w_code;
  logic [RW-1:0]   w_count;
  logic            w_last;
  logic            w_shuf_exit;

  // Round-robin pick: first requester at index >= r_rr, wrapping modulo NP.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_sel   = '0;
    idx     = 0;
    for (int k = 0; k < NP; k++) begin
      idx = int'(r_rr) + k;
      if (idx >= NP) idx = idx - NP;
      if (!w_found && i_req[idx]) begin
        w_found = 1'b1;
        w_sel   = PW'(idx);
      end
    end
  end

  // Anything that is not a clean one-hot code counts as a single card.
  always_comb begin
    w_code = i_cnt[3*w_sel +: 3];
    case (w_code)
      3'b010:  w_count = RW'(2);
      3'b100:  w_count = RW'(4);
      default: w_count = RW'(1);
    endcase
  end

  assign w_last      = (r_remain == RW'(1));
  assign w_shuf_exit = r_shuf_min && i_deck_done;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_new_game)                 w_next = S_START;
        else if (r_started && |i_req)   w_next = S_ARB;
      end
      S_START: w_next = S_SHUF;
      S_SHUF: begin
`ifdef DECK_SCHED_DEAL_EN
        if (w_shuf_exit) w_next = S_DEAL;
`else
        if (w_shuf_exit) w_next = S_IDLE;
`endif
      end
      S_DEAL:  w_next = S_REQ;
      S_ARB:   w_next = w_found ? S_REQ : S_IDLE;
      S_REQ:   if (i_deck_drawn) w_next = S_DLV;
      S_DLV:   w_next = w_last ? S_IDLE : S_GAP;
      // Wait for the deck to drop drawn so each transaction yields one card.
      S_GAP:   if (!i_deck_drawn && i_deck_done) w_next = S_REQ;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr       <= '0;
      r_player   <= '0;
      r_remain   <= '0;
      r_card     <= '0;
      r_grant    <= '0;
      r_started  <= 1'b0;
      r_shuf_min <= 1'b0;
      r_dealing  <= 1'b0;
    end else begin
      case (r_state)
        S_START: r_shuf_min <= 1'b0;
        S_SHUF: begin
          r_shuf_min <= 1'b1;
          if (w_shuf_exit) r_started <= 1'b1;
        end
`ifdef DECK_SCHED_DEAL_EN
        S_DEAL: begin
          r_player  <= '0;
          r_remain  <= RW'(NP*HAND);
          r_dealing <= 1'b1;
        end
`endif
        S_ARB: begin
          if (w_found) begin
            r_player <= w_sel;
            r_remain <= w_count;
            r_grant  <= NP'(1) << w_sel;
            r_rr     <= (w_sel == PW'(NP-1)) ? '0 : w_sel + PW'(1);
          end
        end
        S_REQ: if (i_deck_drawn) r_card <= i_deck_card;
        S_DLV: begin
          r_remain <= r_remain - RW'(1);
          // During the deal the destination advances one player per card.
          if (r_dealing)
            r_player <= (r_player == PW'(NP-1)) ? '0 : r_player + PW'(1);
          if (w_last) begin
            r_grant <= '0;
            if (r_dealing) begin
              r_dealing <= 1'b0;
              r_rr      <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    o_busy        = (r_state != S_IDLE);
    o_deck_start  = (r_state == S_START);
    o_deck_draw   = {2'b00, (r_state == S_REQ)};
    o_card_valid  = (r_state == S_DLV);
    o_card        = o_card_valid ? r_card : 6'd0;
    o_card_player = o_card_valid ? r_player : '0;
    o_grant       = r_grant;
    o_req_done    = '0;
    if (r_state == S_DLV && w_last && !r_dealing)
      o_req_done = NP'(1) << r_player;
  end

endmodule

// File: doc/deck_draw_scheduler.md
Name: deck_draw_scheduler

Overview:
- Sequences the shared card deck for an NP-player UNO game.
- At game start it triggers the deck shuffle. With the optional feature it also deals the opening hands.
- After that it arbitrates draw-1/2/4 requests from players round-robin and splits each request into single-card deck transactions.
- It sits between the player/turn logic and the deck. It is the only block that drives the deck's start and draw inputs.

Parameters:
- NP, 4, number of players (2..8).
- PW, $clog2(NP), player-index width (derived).
- HAND, 7, cards dealt per player in the opening deal.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_new_game  in  1  1-cycle pulse: start a new game (shuffle, then deal)
- i_req  in  NP  per-player draw request; level, held until that player's o_req_done
- i_cnt  in  3*NP  per-player draw code, one-hot: 001=1, 010=2, 100=4 cards; player p uses bits [3p+2:3p]
- o_grant  out  NP  one-hot, player currently being served
- o_req_done  out  NP  1-cycle pulse: request of player p completed
- o_card_valid  out  1  1-cycle pulse: o_card/o_card_player valid
- o_card  out  6  card {color[1:0], value[3:0]}
- o_card_player  out  PW  destination player index
- o_busy  out  1  high in every state except S_IDLE
- o_deck_start  out  1  1-cycle pulse to deck: shuffle
- i_deck_done  in  1  deck idle/ready
- o_deck_draw  out  3  single-card draw request to deck: 001 when requesting, else 000
- i_deck_drawn  in  1  deck has a card available on i_deck_card
- i_deck_card  in  6  card from deck

Behaviour:
- Reset (asynchronous, active-low, i_rst_n; clock i_clk):
  - State S_IDLE; all outputs 0; rr pointer 0; remaining-count 0.
  - Reset mid-transaction aborts immediately; no o_req_done is issued for the aborted request.
- S_IDLE:
  - i_new_game → S_START.
  - Requests are ignored until the first game has been shuffled. A "started" flag is set at S_SHUF exit.
  - If started and any i_req: → S_ARB.
  - i_new_game has priority over a simultaneous i_req.
- S_START: o_deck_start=1 for exactly one cycle → S_SHUF.
- S_SHUF:
  - Wait a minimum of 2 cycles, then wait for i_deck_done=1.
  - On exit → S_DEAL (feature on) or S_IDLE (feature off).
- S_ARB (1 cycle):
  - Select the first requester at index ≥ rr, wrapping modulo NP.
  - Latch the player index and remaining = 1/2/4 decoded from that player's i_cnt.
  - i_cnt not one-hot (000 or multi-bit) is treated as 1.
  - Set o_grant → S_REQ.
  - rr ← grantee+1 mod NP, updated at grant.
- S_REQ:
  - Drive o_deck_draw=001 until i_deck_drawn=1.
  - On that cycle, capture i_deck_card → S_DLV.
  - o_deck_draw drops in the cycle after i_deck_drawn.
- S_DLV:
  - o_card_valid=1 for one cycle with the captured card and player; remaining decrements.
  - If remaining≠0 → S_GAP, else o_req_done[player] pulses in this same cycle, o_grant clears → S_IDLE.
- S_GAP:
  - Hold o_deck_draw=000 until i_deck_drawn=0 and i_deck_done=1 → S_REQ.
  - This guarantees exactly one card per deck transaction.
- Latency: minimum 4 cycles from i_req to the first o_card_valid (IDLE→ARB→REQ→DLV), with the deck answering the same cycle.
- Requests deasserted mid-service are ignored; service completes with the latched count.
- A new i_req from the current grantee is not re-granted before o_req_done.
- i_new_game outside S_IDLE is ignored (no queueing).
- Cards are forwarded unmodified. Wild cards (value 13/14) keep their color bits.

Optional Feature:
- Macro DECK_SCHED_DEAL_EN.
- Defined:
  - S_DEAL deals HAND cards to each player, round-robin player 0,1,..,NP-1,0,..; NP*HAND cards total.
  - Each card uses the S_REQ/S_DLV/S_GAP path with o_card_player = deal index.
  - o_req_done is not pulsed during the deal.
  - The deal ends with rr=0 → S_IDLE.
- Undefined: S_SHUF goes directly to S_IDLE, and hands come from ordinary draw requests.

Test Plan:
- Reset with i_rst_n=0 mid-S_REQ → all outputs 0 within the reset cycle, o_deck_draw=000; after release, state S_IDLE with rr=0.
- i_new_game pulse, deck raises i_deck_done 5 cycles later → exactly one o_deck_start pulse; o_busy high until exit from S_SHUF.
- NP=4, feature on, deck model answers immediately → 28 o_card_valid pulses; o_card_player sequence 0,1,2,3,0,…; no o_req_done.
- Player 2 requests code 100, deck model returns cards 0x05, 0x1A, 0x2C, 0x3E → four o_card_valid pulses with those cards, all to player 2; one o_req_done[2] on the 4th.
- Players 1 and 3 request together with rr=0 → player 1 served first; then player 3; next simultaneous 1 and 3 request → player 1 again (rr=0 after wrap).
- i_cnt=011 for player 0 → exactly one card delivered, then o_req_done[0].
